// File: rtl/card_draw_arbiter.sv
// card_draw_arbiter: round-robin sharing of one 4-bit LFSR between player and dealer,
// rejection-sampling its output into card ranks 1..13 with a fixed fallback card.
module card_draw_arbiter #(
   parameter int MAX_CARDS = 11,
   parameter int MAX_RETRY = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_player,
   input  logic       req_dealer,
   input  logic       clear,
   input  logic [3:0] rng_value,
   output logic       rng_enable,
   output logic       ack_player,
   output logic       ack_dealer,
   output logic       card_valid,
   output logic       card_owner,
   output logic [3:0] card_rank,
   output logic [3:0] card_points,
   output logic [3:0] player_count,
   output logic [3:0] dealer_count,
   output logic       busy
);
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam logic [RW-1:0] MAXR = RW'(MAX_RETRY);
   localparam logic [3:0] MAXC = 4'(MAX_CARDS);
   typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, SAMPLE = 2'd2, DELIVER = 2'd3} state_t;
   state_t state_q;
   logic owner_q, ptr_q;
   logic [RW-1:0] retry_q;
   logic [3:0] p_cnt_q, d_cnt_q;
   logic elig_p, elig_d, accept;
   logic [3:0] rank, pts;
   always_comb begin
      elig_p = req_player && (p_cnt_q < MAXC);
      elig_d = req_dealer && (d_cnt_q < MAXC);
      accept = (rng_value >= 4'd1) && (rng_value <= 4'd13);
      rank = accept ? rng_value : 4'd10;
      pts = (rank > 4'd10) ? 4'd10 : rank;
   end
   assign player_count = p_cnt_q;
   assign dealer_count = d_cnt_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         ptr_q <= 1'b0;
         retry_q <= '0;
         p_cnt_q <= 4'd0;
         d_cnt_q <= 4'd0;
         rng_enable <= 1'b0;
         ack_player <= 1'b0;
         ack_dealer <= 1'b0;
         card_valid <= 1'b0;
         card_owner <= 1'b0;
         card_rank <= 4'd0;
         card_points <= 4'd0;
         busy <= 1'b0;
      end else begin
         rng_enable <= 1'b0;
         ack_player <= 1'b0;
         ack_dealer <= 1'b0;
         card_valid <= 1'b0;
         case (state_q)
            IDLE: if (elig_p || elig_d) begin
               owner_q <= (elig_p && elig_d) ? ptr_q : elig_d;
               state_q <= STEP;
               rng_enable <= 1'b1;
               busy <= 1'b1;
            end
            STEP: state_q <= SAMPLE;
            SAMPLE: if (accept || retry_q == MAXR) begin
               state_q <= DELIVER;
               card_valid <= 1'b1;
               card_owner <= owner_q;
               card_rank <= rank;
               card_points <= pts;
               ack_player <= !owner_q;
               ack_dealer <= owner_q;
            end else begin
               retry_q <= retry_q + 1'b1;
               state_q <= STEP;
               rng_enable <= 1'b1;
            end
            DELIVER: begin
               state_q <= IDLE;
               busy <= 1'b0;
               retry_q <= '0;
               ptr_q <= !owner_q;
               if (!owner_q) p_cnt_q <= p_cnt_q + 4'd1;
               else d_cnt_q <= d_cnt_q + 4'd1;
            end
            default: state_q <= IDLE;
         endcase
         // a new round wins over the increment of a card delivered on the same edge
         if (clear) begin
            p_cnt_q <= 4'd0;
            d_cnt_q <= 4'd0;
         end
      end
   end
endmodule

// File: tb/tb_card_draw_arbiter.sv
// tb_card_draw_arbiter: directed and random draws checked against a transaction-level
// model of arbitration, rejection sampling, hand counts and draw latency.
module tb_card_draw_arbiter;
   localparam int MC = 2;
   localparam int MR = 7;
   logic clk = 1'b0;
   logic reset, req_player, req_dealer, clear;
   logic [3:0] rng_value;
   logic rng_enable, ack_player, ack_dealer, card_valid, card_owner, busy;
   logic [3:0] card_rank, card_points, player_count, dealer_count;
   int total = 0;
   int bad = 0;
   int pulses = 0;
   logic [3:0] rng_q[$];
   logic [3:0] samples[$];
   int m_cnt[2];
   logic m_last;
   card_draw_arbiter #(.MAX_CARDS(MC), .MAX_RETRY(MR)) dut (
      .clk(clk), .reset(reset), .req_player(req_player), .req_dealer(req_dealer),
      .clear(clear), .rng_value(rng_value), .rng_enable(rng_enable),
      .ack_player(ack_player), .ack_dealer(ack_dealer), .card_valid(card_valid),
      .card_owner(card_owner), .card_rank(card_rank), .card_points(card_points),
      .player_count(player_count), .dealer_count(dealer_count), .busy(busy)
   );
   always #5 clk = ~clk;
   // LFSR stand-in: each enable pulse exposes the next queued sample in the following cycle
   always @(negedge clk) if (rng_enable) begin
      pulses++;
      rng_value = (rng_q.size() != 0) ? rng_q.pop_front() : 4'd15;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask
   function automatic void model_draw(input logic [3:0] s[$], output int np, output logic [3:0] rk);
      bit found = 0;
      np = MR + 1;
      rk = 4'd10;
      for (int i = 0; i <= MR; i++)
         if (!found && s[i] >= 1 && s[i] <= 13) begin
            found = 1;
            np = i + 1;
            rk = s[i];
         end
   endfunction
   function automatic void rand_samples();
      bool_dummy: begin end
      samples.delete();
      for (int i = 0; i < MR + 1; i++) begin
         int r = $urandom_range(0, 3);
         samples.push_back(r == 0 ? 4'(($urandom_range(0, 2) == 0) ? 0 : 13 + $urandom_range(1, 2))
                                  : 4'($urandom_range(1, 13)));
      end
      if ($urandom_range(0, 9) == 0) foreach (samples[i]) samples[i] = 4'd15;
   endfunction
   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
   endtask
   // one complete draw from the E0 edge to the IDLE cycle after DELIVER
   task automatic run_draw(input logic rp, input logic rd, input bit clr_dlv);
      int cyc = 0;
      int np;
      logic [3:0] rk;
      logic own;
      bit ep, ed;
      ep = rp && (m_cnt[0] < MC);
      ed = rd && (m_cnt[1] < MC);
      own = (ep && ed) ? !m_last : ed;
      model_draw(samples, np, rk);
      rng_q = samples;
      pulses = 0;
      req_player = rp;
      req_dealer = rd;
      do begin
         @(negedge clk);
         cyc++;
      end while (!card_valid && cyc < 40);
      chk("deliver_seen", cyc < 40, 1);
      chk("deliver_cycle", cyc, 2 * np + 1);
      chk("rng_pulses", pulses, np);
      chk("owner", card_owner, own);
      chk("rank", card_rank, rk);
      chk("points", card_points, rk > 10 ? 10 : rk);
      chk("ack_player", ack_player, !own);
      chk("ack_dealer", ack_dealer, own);
      chk("count_at_deliver", own ? dealer_count : player_count, m_cnt[own]);
      if (own) req_dealer = 1'b0;
      else req_player = 1'b0;
      clear = clr_dlv;
      m_last = own;
      if (clr_dlv) begin
         m_cnt[0] = 0;
         m_cnt[1] = 0;
      end else m_cnt[own]++;
      @(negedge clk);
      clear = 1'b0;
      chk("busy_after", busy, 0);
      chk("valid_after", card_valid, 0);
      chk("acks_after", {ack_player, ack_dealer}, 0);
      chk("player_count", player_count, m_cnt[0]);
      chk("dealer_count", dealer_count, m_cnt[1]);
   endtask
   task automatic expect_no_grant(input int n);
      bit seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (busy || ack_player || ack_dealer || card_valid || rng_enable) seen = 1;
      end
      chk("no_grant", seen, 0);
   endtask
   initial begin
      reset = 1'b1;
      req_player = 1'b0;
      req_dealer = 1'b0;
      clear = 1'b0;
      rng_value = 4'd0;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      m_last = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_outputs", {rng_enable, ack_player, ack_dealer, card_valid, card_owner, busy}, 0);
      chk("rst_card", {card_rank, card_points}, 0);
      chk("rst_counts", {player_count, dealer_count}, 0);
      samples = {4'd12, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
      run_draw(1, 0, 0);
      samples = {4'd14, 4'd15, 4'd5, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
      run_draw(0, 1, 0);
      pulse_clear();
      chk("clear_counts", {player_count, dealer_count}, 0);
      samples = {4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
      run_draw(1, 0, 0);
      samples = {4'd0, 4'd6, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
      run_draw(1, 0, 0);
      req_player = 1'b1;
      expect_no_grant(20);
      chk("full_count", player_count, MC);
      pulse_clear();
      samples = {4'd13, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
      run_draw(1, 0, 0);
      rng_q = {4'd4};
      req_player = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req_player = 1'b0;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      m_last = 1'b1;
      chk("rst_mid_outputs", {rng_enable, ack_player, ack_dealer, card_valid, busy}, 0);
      chk("rst_mid_card", {card_owner, card_rank, card_points}, 0);
      chk("rst_mid_counts", {player_count, dealer_count}, 0);
      for (int i = 0; i < 4; i++) begin
         rand_samples();
         run_draw(1, 1, 0);
      end
      req_player = 1'b1;
      req_dealer = 1'b1;
      expect_no_grant(6);
      req_player = 1'b0;
      req_dealer = 1'b0;
      pulse_clear();
      samples = {4'd7, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
      run_draw(0, 1, 1);
      for (int i = 0; i < 60; i++) begin
         logic rp, rd;
         rp = 1'($urandom_range(0, 1));
         rd = 1'($urandom_range(0, 1));
         if ((rp && m_cnt[0] < MC) || (rd && m_cnt[1] < MC)) begin
            rand_samples();
            run_draw(rp, rd, $urandom_range(0, 7) == 0);
         end else begin
            req_player = rp;
            req_dealer = rd;
            expect_no_grant(5);
            req_player = 1'b0;
            req_dealer = 1'b0;
            pulse_clear();
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/card_draw_arbiter.md
# card_draw_arbiter

Shares the single 4-bit LFSR random source between the player and dealer hand logic of the blackjack game. The block arbitrates card requests round-robin and pulses the LFSR enable. It rejection-samples the LFSR output into a card rank 1..13, then returns rank and blackjack point value to the winning requester. It sits between the hand/score FSMs and the LFSR seed generator, and keeps a per-hand card count that blocks requests once a hand is full.

## Interface

**Parameters**
- MAX_CARDS, 11: cards per hand. At this count, further requests from that hand are ignored.
- MAX_RETRY, 7: number of rejected samples tolerated before the fallback card is issued.

**Ports**
- clk  in  1  system clock
- reset  in  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- req_player  in  1  level request; held until ack_player
- req_dealer  in  1  level request; held until ack_dealer
- clear  in  1  new round; zeroes both card counts
- rng_value  in  4  LFSR output; reflects the new state in the cycle after rng_enable
- rng_enable  out  1  one-cycle LFSR step pulse
- ack_player  out  1  one-cycle grant-complete pulse
- ack_dealer  out  1  one-cycle grant-complete pulse
- card_valid  out  1  card outputs valid (DELIVER cycle)
- card_owner  out  1  0 = player, 1 = dealer
- card_rank  out  4  1..13 (1 = ace, 11/12/13 = J/Q/K)
- card_points  out  4  1..10
- player_count  out  4  cards dealt to player
- dealer_count  out  4  cards dealt to dealer
- busy  out  1  state ≠ IDLE

## Operation

**Reset values**
- All outputs 0; state IDLE.
- Retry counter 0; round-robin pointer = player.
- Counts 0.

**Eligibility and arbitration**
- A hand is eligible when its req = 1 and its count < MAX_CARDS.

**FSM states**
- **IDLE**
  - If exactly one requester is eligible, latch it as owner and go to STEP.
  - If both are eligible, the pointer picks the owner. The pointer starts at player and flips to the other requester after every DELIVER.
  - If none are eligible, stay in IDLE.
- **STEP**
  - rng_enable = 1 for this cycle only; go to SAMPLE.
- **SAMPLE** (evaluate rng_value)
  - Value 1..13: accept; rank = value; go to DELIVER.
  - Value 0, 14 or 15: reject.
    - If retry < MAX_RETRY: retry++ and go to STEP.
    - If retry = MAX_RETRY: rank = 10 (fallback); go to DELIVER.
- **DELIVER**
  - card_valid = 1 and the owner's ack = 1, for one cycle.
  - card_rank, card_points and card_owner are registered on entry.
  - Owner's count increments at the exit edge; retry is cleared.
  - Go to IDLE.

**Card outputs**
- card_points = rank for ranks 1..10; 10 for ranks 11..13.
- card_rank, card_points and card_owner hold their last values outside DELIVER. card_valid qualifies them.

**Boundary conditions**
- Requester handshake: the requester deasserts req in the cycle after ack. A req still high in IDLE after that is a new request.
- Full hand: a request from a full hand is never acked until clear. The other hand is still served.
- clear:
  - clear zeroes both counts in any state.
  - If clear coincides with the DELIVER exit edge, clear wins: count = 0, no increment. The card is still delivered.
  - clear does not abort an in-flight draw.
- Withdrawn request: dropping req mid-draw does not abort the draw. The card is delivered and acked anyway.
- Counts never exceed MAX_CARDS.
- Reset in any state returns to IDLE next edge with all reset values. No ack and no card_valid are produced for the aborted draw.

## Timing

- Request sampled in IDLE at edge E0.
  - STEP is cycle 1 (rng_enable high).
  - SAMPLE is cycle 2.
  - DELIVER is cycle 3 (ack, card_valid).
  - IDLE again in cycle 4.
- Each rejection adds 2 cycles. Worst-case DELIVER is cycle 2·(MAX_RETRY+1)+1 = 17 at defaults.
- Back-to-back: with a req already pending, the next grant is taken in the cycle-4 IDLE. Minimum request-to-request spacing is 4 cycles.
- rng_enable is never high outside STEP. It pulses exactly once per sample.

## Test plan

- **Single accept:** req_player=1; model returns 12 in SAMPLE → cycle 3: ack_player=1, card_valid=1, owner=0, rank=12, points=10; player_count=1 in cycle 4.
- **Rejection:** req_dealer=1; samples 14, 15, 5 → three rng_enable pulses (cycles 1, 3, 5); DELIVER at cycle 7: rank=5, points=5, owner=1, dealer_count=1.
- **Retry exhaustion:** rng_value held at 15 with MAX_RETRY=7 → 8 rng_enable pulses, DELIVER at cycle 17 with rank=10, points=10; retry returns to 0.
- **Simultaneous requests:** both req high after reset → player served first (ack_player cycle 3), dealer next (ack_dealer cycle 7), order alternating while both are held.
- **Full hand:** MAX_CARDS=2; player draws twice, third req_player held 20 cycles → no ack, player_count=2; pulse clear → count 0, pending req then granted.
- **Reset and clear collision:** reset asserted in SAMPLE → next cycle IDLE, all outputs 0, no ack. clear asserted on the DELIVER cycle → card_valid=1 delivered, count reads 0 afterward.
